alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side counterpart of the 8-bit ALU. It consumes a byte-wide instruction stream and owns the accumulator (ACC), the X register and the carry flag (C).
- For each instruction it drives the ALU operand, op and carry-in inputs, captures q/cout, and writes back the destination register and flag.
- When an instruction requests it, the result is emitted on a valid/ready output port.
- The ALU itself is instantiated beside this block, not inside it.

Parameters:
RESET_ACC, 8'h00, reset value of ACC
RESET_X, 8'h00, reset value of X
RESET_C, 1'b0, reset value of carry flag

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction/immediate byte valid
in_data  in  8  instruction or immediate byte
in_ready  out  1  byte accepted when in_valid & in_ready
res_valid  out  1  result byte valid
res_data  out  8  result byte
res_ready  in  1  consumer accepts result
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_op  out  4  ALU op
alu_xy  out  1  ALU xy select
alu_cin  out  1  ALU carry-in
alu_q  in  8  ALU result
alu_cout  in  1  ALU carry-out
acc_q  out  8  ACC (observation)
x_q  out  8  X (observation)
c_q  out  1  carry flag (observation)

Behaviour:
- Instruction byte fields:
  - [7:4] op, passed to alu_op.
  - [3] dst: 0 = ACC, 1 = X.
  - [2] bsrc: 0 = register, 1 = immediate from the next byte.
  - [1] fwe: update C from alu_cout.
  - [0] emit: present the result on the result port.
- Operands:
  - alu_a = dst register.
  - alu_b = immediate if bsrc=1; otherwise the other register (X when dst=ACC, ACC when dst=X).
  - alu_cin = C.
  - alu_xy = dst.
  - The ALU outputs are purely combinational on the registered instruction, operands and C.
- FSM states: IDLE, IMM, EXEC, OUT.
  - IDLE: in_ready=1. On handshake, latch the instruction. Go to IMM if bsrc=1, else EXEC.
  - IMM: in_ready=1. On handshake, latch the immediate and go to EXEC. Hold in IMM indefinitely while in_valid=0.
  - EXEC: one cycle, in_ready=0. At the end of the cycle, write alu_q to dst and, if fwe, write alu_cout to C. Latch alu_q into res_data. Go to OUT if emit, else IDLE.
  - OUT: res_valid=1, in_ready=0. On res_ready, go to IDLE. res_data stays stable while res_valid=1 and res_ready=0.
- Latency: from the last byte handshake to register update is exactly 1 cycle (EXEC). Minimum throughput is 2 cycles per register-operand instruction and 3 per immediate instruction, plus OUT cycles.
- res_valid is asserted only in OUT. in_ready is never asserted together with res_valid.
- Reset (async, any state including mid-instruction or mid-OUT):
  - FSM returns to IDLE; ACC=RESET_ACC, X=RESET_X, C=RESET_C.
  - res_valid=0, res_data=0, in_ready=1 after release.
  - Latched instruction and immediate are cleared to 0.
  - Any partially received instruction is discarded.
- Boundary conditions:
  - When fwe=0, C is unchanged even if alu_cout=1.
  - When dst=X and bsrc=0, alu_b = ACC.
  - A register written in EXEC is visible to the next instruction's operands; no forwarding hazard exists because it is multi-cycle.
  - 8-bit wrap-around is the ALU's responsibility; this block never widens results.

Decomposition:
- Shared package: field-position constants (OP_MSB/LSB, DST_BIT, BSRC_BIT, FWE_BIT, EMIT_BIT) and the FSM state enum (IDLE, IMM, EXEC, OUT), both reused by the assembler-side bench model.
- No sub-module; the block is a single FSM plus a register file.

Test Plan:
- Reset, then 0x46 followed by 0x7F (add imm to ACC, fwe, no emit) with the real alu attached -> ACC=0x7F, C=0, res_valid never asserted, in_ready low for exactly 1 cycle after the immediate.
- Continuing: 0x46, 0x81 -> ACC=0x00, C=1 (wrap-around with carry out).
- Continuing: 0x93 (op 1001, rotate-left-through-carry, fwe, emit) -> ACC=0x01, C=0, res_valid=1 with res_data=0x01. Hold res_ready=0 for 5 cycles -> res_data stable and in_ready=0 throughout.
- 0x4C then 0x05 (add imm to X, fwe=0) when X=0xFF -> X=0x04, C unchanged from its prior value.
- Drop in_valid for 4 cycles between opcode 0x46 and its immediate -> FSM waits in IMM and the result is identical to the back-to-back case.
- Assert rst_n=0 during OUT with res_valid=1 -> res_valid drops immediately (asynchronously), ACC/X/C return to their parameter values, and the next instruction executes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: instruction field positions and FSM states.
// The instruction layout is also used by the assembler-side bench model.
package alu_sequencer_pkg;

  localparam int DATA_W   = 8;
  localparam int OP_W     = 4;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 4;
  localparam int DST_BIT  = 3;
  localparam int BSRC_BIT = 2;
  localparam int FWE_BIT  = 1;
  localparam int EMIT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    EXEC = 2'd2,
    OUT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the external 8-bit ALU: owns ACC, X and the carry flag,
// feeds the ALU from the latched instruction and writes the result back in EXEC.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_ACC = 8'h00,
  parameter logic [7:0] RESET_X   = 8'h00,
  parameter logic       RESET_C   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_xy,
  output logic       alu_cin,
  input  logic [7:0] alu_q,
  input  logic       alu_cout,
  output logic [7:0] acc_q,
  output logic [7:0] x_q,
  output logic       c_q
);

  seq_state_e state_q, state_d;

  logic [7:0] instr_q;
  logic [7:0] imm_q;
  logic       exec;

  logic dst, bsrc, fwe, emit;

  assign dst  = instr_q[DST_BIT];
  assign bsrc = instr_q[BSRC_BIT];
  assign fwe  = instr_q[FWE_BIT];
  assign emit = instr_q[EMIT_BIT];

  // Operands come straight from registered state, so the ALU path is settled by EXEC.
  assign alu_a   = dst ? x_q : acc_q;
  assign alu_b   = bsrc ? imm_q : (dst ? acc_q : x_q);
  assign alu_op  = instr_q[OP_MSB:OP_LSB];
  assign alu_xy  = dst;
  assign alu_cin = c_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = in_data[BSRC_BIT] ? IMM : EXEC;
      IMM:     if (in_valid) state_d = EXEC;
      EXEC:    state_d = emit ? OUT : IDLE;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    exec      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      IMM:     in_ready  = 1'b1;
      EXEC:    exec      = 1'b1;
      OUT:     res_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Register file and instruction latches; a reset mid-instruction discards the
  // partial instruction by clearing both latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      imm_q    <= '0;
      acc_q    <= RESET_ACC;
      x_q      <= RESET_X;
      c_q      <= RESET_C;
      res_data <= '0;
    end else begin
      if (state_q == IDLE && in_valid) instr_q <= in_data;
      if (state_q == IMM && in_valid)  imm_q   <= in_data;
      if (exec) begin
        if (dst) x_q   <= alu_q;
        else     acc_q <= alu_q;
        if (fwe) c_q <= alu_cout;
        res_data <= alu_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached beside it
// and an instruction-level reference model of ACC/X/C and the result port.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam logic [7:0] P_ACC = 8'h00;
  localparam logic [7:0] P_X   = 8'h00;
  localparam logic       P_C   = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic [7:0] alu_a, alu_b, alu_q;
  logic [3:0] alu_op;
  logic       alu_xy, alu_cin, alu_cout;
  logic [7:0] acc_q, x_q;
  logic       c_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_acc, m_x;
  logic       m_c;

  always #5 clk = ~clk;

  alu_sequencer #(.RESET_ACC(P_ACC), .RESET_X(P_X), .RESET_C(P_C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout),
    .acc_q(acc_q), .x_q(x_q), .c_q(c_q)
  );

  // Stand-in ALU: returns {cout, q}.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    case (op)
      4'd0:  return {1'b0, b};
      4'd1:  return {1'b0, a & b};
      4'd2:  return {1'b0, a | b};
      4'd3:  return {1'b0, a ^ b};
      4'd4:  return {1'b0, a} + {1'b0, b};
      4'd5:  return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd6:  return {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'd7:  return {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
      4'd8:  return {a, 1'b0};
      4'd9:  return {a, cin};
      4'd10: return {a[0], 1'b0, a[7:1]};
      4'd11: return {a[0], cin, a[7:1]};
      4'd12: return {1'b0, a} + 9'd1;
      4'd13: return {1'b0, a} - 9'd1;
      4'd14: return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb {alu_cout, alu_q} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  task automatic model_reset();
    m_acc = P_ACC;
    m_x   = P_X;
    m_c   = P_C;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s handshake_timeout: in_ready=%b required 1", tag, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Runs one instruction and checks operands, write-back and the result port.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] imm, input int gap,
                           input int hold, input bit rst_in_out, input string tag);
    logic [3:0] op;
    logic       dst, bsrc, fwe, emit;
    logic [7:0] ea, eb, hold_data;
    logic [8:0] r;
    op   = ins[OP_MSB:OP_LSB];
    dst  = ins[DST_BIT];
    bsrc = ins[BSRC_BIT];
    fwe  = ins[FWE_BIT];
    emit = ins[EMIT_BIT];
    ea   = dst ? m_x : m_acc;
    eb   = bsrc ? imm : (dst ? m_acc : m_x);
    r    = alu_fn(op, ea, eb, m_c);

    send_byte(ins, tag);
    if (bsrc) begin
      repeat (gap) @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s imm_wait: in_ready=%b res_valid=%b required 1 0", tag, in_ready, res_valid);
      end
      send_byte(imm, tag);
    end

    n_cmp++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s exec_handshake: in_ready=%b res_valid=%b required 0 0", tag, in_ready, res_valid);
    end
    n_cmp++;
    if (alu_a !== ea || alu_b !== eb || alu_op !== op || alu_xy !== dst || alu_cin !== m_c) begin
      n_err++;
      $display("FAIL %s exec_operands: a=%h b=%h op=%h xy=%b cin=%b required %h %h %h %b %b",
               tag, alu_a, alu_b, alu_op, alu_xy, alu_cin, ea, eb, op, dst, m_c);
    end

    if (dst) m_x = r[7:0];
    else     m_acc = r[7:0];
    if (fwe) m_c = r[8];

    @(negedge clk);
    n_cmp++;
    if (acc_q !== m_acc || x_q !== m_x || c_q !== m_c) begin
      n_err++;
      $display("FAIL %s writeback: acc=%h x=%h c=%b required %h %h %b", tag, acc_q, x_q, c_q, m_acc, m_x, m_c);
    end

    if (!emit) begin
      n_cmp++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s after_exec: res_valid=%b in_ready=%b required 0 1", tag, res_valid, in_ready);
      end
      return;
    end

    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== r[7:0] || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s result: res_valid=%b res_data=%h in_ready=%b required 1 %h 0",
               tag, res_valid, res_data, in_ready, r[7:0]);
    end
    hold_data = r[7:0];

    if (rst_in_out) begin
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s async_reset_port: res_valid=%b res_data=%h in_ready=%b required 0 00 1",
                 tag, res_valid, res_data, in_ready);
      end
      n_cmp++;
      if (acc_q !== m_acc || x_q !== m_x || c_q !== m_c) begin
        n_err++;
        $display("FAIL %s async_reset_regs: acc=%h x=%h c=%b required %h %h %b", tag, acc_q, x_q, c_q, m_acc, m_x, m_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end

    repeat (hold) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== hold_data || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s result_hold: res_valid=%b res_data=%h in_ready=%b required 1 %h 0",
                 tag, res_valid, res_data, in_ready, hold_data);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s result_ack: res_valid=%b in_ready=%b required 0 1", tag, res_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (acc_q !== P_ACC || x_q !== P_X || c_q !== P_C) begin
      n_err++;
      $display("FAIL reset_regs: acc=%h x=%h c=%b required %h %h %b", acc_q, x_q, c_q, P_ACC, P_X, P_C);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_port: in_ready=%b res_valid=%b res_data=%h required 1 0 00", in_ready, res_valid, res_data);
    end
  endtask

  task automatic test_add_imm();
    run_instr(8'h46, 8'h7F, 0, 0, 0, "add_imm_7f");
    n_cmp++;
    if (acc_q !== 8'h7F || c_q !== 1'b0) begin
      n_err++;
      $display("FAIL add_imm_7f_abs: acc=%h c=%b required 7f 0", acc_q, c_q);
    end
    run_instr(8'h46, 8'h81, 0, 0, 0, "add_imm_wrap");
    n_cmp++;
    if (acc_q !== 8'h00 || c_q !== 1'b1) begin
      n_err++;
      $display("FAIL add_imm_wrap_abs: acc=%h c=%b required 00 1", acc_q, c_q);
    end
  endtask

  task automatic test_rlc_emit();
    run_instr(8'h93, 8'h00, 0, 5, 0, "rlc_emit");
    n_cmp++;
    if (acc_q !== 8'h01 || c_q !== 1'b0) begin
      n_err++;
      $display("FAIL rlc_emit_abs: acc=%h c=%b required 01 0", acc_q, c_q);
    end
  endtask

  task automatic test_x_no_fwe();
    run_instr(8'h46, 8'hFF, 0, 0, 0, "set_carry");
    run_instr(8'h0C, 8'hFF, 0, 0, 0, "load_x");
    run_instr(8'h4C, 8'h05, 0, 0, 0, "add_x_nofwe");
    n_cmp++;
    if (x_q !== 8'h04 || c_q !== 1'b1) begin
      n_err++;
      $display("FAIL add_x_nofwe_abs: x=%h c=%b required 04 1", x_q, c_q);
    end
    run_instr(8'h48, 8'h00, 0, 0, 0, "x_plus_acc_reg");
    run_instr(8'h5B, 8'h00, 0, 2, 0, "adc_x_acc_emit");
  endtask

  task automatic test_imm_gap();
    run_instr(8'h46, 8'h3C, 4, 0, 0, "imm_gap4");
    run_instr(8'h67, 8'h11, 4, 1, 0, "sub_imm_gap_emit");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0, "random");
    end
  endtask

  task automatic test_reset_during_out();
    run_instr(8'h03, 8'h00, 0, 0, 1, "reset_in_out");
    run_instr(8'h46, 8'h2A, 0, 0, 0, "post_reset_add");
    n_cmp++;
    if (acc_q !== 8'h2A) begin
      n_err++;
      $display("FAIL post_reset_abs: acc=%h required 2a", acc_q);
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_rlc_emit();
    test_x_no_fwe();
    test_imm_gap();
    test_random();
    test_reset_during_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
